// File: rtl/tcm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcm_pkg
// Description : Shared constants and helpers for the TCM RAM block.
//               Holds the response error code and a constant-evaluable clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package tcm_pkg;

    // Response status carried on r_err_o
    localparam logic c_RESP_OK  = 1'b0;
    localparam logic c_RESP_ERR = 1'b1;

    // Ceiling log2, usable in parameter/localparam elaboration.
    // clog2(1) = 0, clog2(2) = 1, clog2(4096) = 12.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : tcm_pkg
`default_nettype wire

// File: rtl/tcm_array.sv
`default_nettype none
// ============================================================================
// Module      : tcm_array
// Description : DW x DEPTH storage with byte-lane write strobes and a
//               synchronous, enable-gated read port. No reset on the array or
//               the read register: the read register only changes when re_i
//               is high, so it holds the last word read for as long as the
//               consumer stalls.
// Ports       : clk      - clock, rising edge
//               we_i     - write enable (already qualified by the caller)
//               waddr_i  - write word index
//               wdata_i  - write data
//               wstrb_i  - byte-lane write enables
//               re_i     - read enable (already qualified by the caller)
//               raddr_i  - read word index
//               rdata_o  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module tcm_array
    import tcm_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4096,
    localparam int AW   = clog2(DEPTH),
    localparam int NB   = DW / 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [NB-1:0] wstrb_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Read and write share one edge; a same-word read returns the pre-write
    // contents because both use non-blocking semantics.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < NB; k++) begin
                if (wstrb_i[k]) begin
                    mem_q[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : tcm_array
`default_nettype wire

// File: rtl/tcm_ram.sv
`default_nettype none
// ============================================================================
// Module      : tcm_ram
// Description : Tightly-coupled memory with one write port and one
//               valid/ready read port. Reads have 1-cycle latency and full
//               back-to-back throughput; a stalled response is held stable.
//               Misaligned or out-of-range reads return an error with zero
//               data; such writes are dropped.
// Config      : TCM_RAM_BYPASS_EN - when defined, a read and a write to the
//               same word in the same cycle return the old word merged with
//               the newly strobed bytes. When undefined, the old word is
//               returned.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               w_en_i     - write request
//               w_addr_i   - write byte address
//               w_data_i   - write data
//               w_strb_i   - byte-lane write enables
//               r_req_i    - read request
//               r_addr_i   - read byte address
//               r_gnt_o    - read accepted this cycle
//               r_valid_o  - read response valid
//               r_ready_i  - consumer accepts response
//               r_data_o   - read response data
//               r_err_o    - response error flag (qualified by r_valid_o)
// Revision    : 1.0 - initial release
// ============================================================================
module tcm_ram
    import tcm_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_en_i,
    input  logic [31:0]     w_addr_i,
    input  logic [DW-1:0]   w_data_i,
    input  logic [DW/8-1:0] w_strb_i,
    input  logic            r_req_i,
    input  logic [31:0]     r_addr_i,
    output logic            r_gnt_o,
    output logic            r_valid_o,
    input  logic            r_ready_i,
    output logic [DW-1:0]   r_data_o,
    output logic            r_err_o
);

    localparam int          AW         = clog2(DEPTH);
    localparam int          OFS        = clog2(DW / 8);
    localparam int          NB         = DW / 8;
    localparam logic [31:0] c_OFS_MASK = 32'((64'd1 << OFS) - 64'd1);

    // ------------------------------------------------------------------
    // Address decode. The shift form of the range check stays valid when
    // OFS+AW reaches 32 (shift-out yields zero).
    // ------------------------------------------------------------------
    logic [AW-1:0] w_w_idx;
    logic [AW-1:0] w_r_idx;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_accept;
    logic          w_collide;
    logic [DW-1:0] w_strb_mask;
    logic [DW-1:0] w_arr_rdata;
    logic [DW-1:0] w_merged;

    assign w_w_idx  = w_addr_i[OFS +: AW];
    assign w_r_idx  = r_addr_i[OFS +: AW];

    assign w_wr_ok  = ~rst & w_en_i
                    & ((w_addr_i & c_OFS_MASK) == 32'd0)
                    & ((w_addr_i >> (OFS + AW)) == 32'd0);
    assign w_rd_ok  = ((r_addr_i & c_OFS_MASK) == 32'd0)
                    & ((r_addr_i >> (OFS + AW)) == 32'd0);

    // ------------------------------------------------------------------
    // Handshake: a new read is taken only if the output slot is empty or
    // is being drained this cycle.
    // ------------------------------------------------------------------
    logic resp_valid_q, resp_valid_d;
    logic resp_err_q,   resp_err_d;
    logic [DW-1:0] byp_mask_q, byp_mask_d;
    logic [DW-1:0] byp_data_q, byp_data_d;

    assign r_gnt_o  = ~rst & r_req_i & (~resp_valid_q | r_ready_i);
    assign w_accept = r_gnt_o;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        assign w_strb_mask[k*8 +: 8] = {8{w_strb_i[k]}};
    end

`ifdef TCM_RAM_BYPASS_EN
    assign w_collide = w_accept & w_rd_ok & w_wr_ok & (w_r_idx == w_w_idx);
`else
    assign w_collide = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output-hold state. The array read register holds the old word; the
    // bypass mask/data are captured at accept time and overlaid on it, so
    // the merged response also stays stable through a stall.
    // ------------------------------------------------------------------
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        byp_mask_d   = byp_mask_q;
        byp_data_d   = byp_data_q;
        if (w_accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = w_rd_ok ? c_RESP_OK : c_RESP_ERR;
            byp_mask_d   = w_collide ? w_strb_mask : '0;
            byp_data_d   = w_data_i;
        end else if (r_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= c_RESP_OK;
            byp_mask_q   <= '0;
            byp_data_q   <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            byp_mask_q   <= byp_mask_d;
            byp_data_q   <= byp_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Error reads never touch the array.
    // ------------------------------------------------------------------
    tcm_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (w_wr_ok),
        .waddr_i (w_w_idx),
        .wdata_i (w_data_i),
        .wstrb_i (w_strb_i),
        .re_i    (w_accept & w_rd_ok),
        .raddr_i (w_r_idx),
        .rdata_o (w_arr_rdata)
    );

    assign w_merged = (w_arr_rdata & ~byp_mask_q) | (byp_data_q & byp_mask_q);

    // Outputs are forced low combinationally while reset is held so that the
    // very first reset cycle is already quiet.
    assign r_valid_o = resp_valid_q & ~rst;
    assign r_err_o   = resp_valid_q & resp_err_q & ~rst;
    assign r_data_o  = (resp_valid_q && (resp_err_q == c_RESP_OK) && !rst) ? w_merged : '0;

endmodule : tcm_ram
`default_nettype wire

// File: tb/tb_tcm_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcm_ram
// Description : Self-checking bench for tcm_ram (DW=32, DEPTH=4096).
//               Directed scenarios followed by randomized traffic, checked
//               against a word-array reference model and a one-slot
//               response model.
// Config      : TCM_RAM_BYPASS_EN selects the expected collision result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcm_ram;

    localparam int DW    = 32;
    localparam int DEPTH = 4096;
    localparam int NB    = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic [31:0]   w_addr;
    logic [DW-1:0] w_data;
    logic [NB-1:0] w_strb;
    logic          r_req;
    logic [31:0]   r_addr;
    logic          r_gnt;
    logic          r_valid;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic          r_err;

    tcm_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_en_i    (w_en),
        .w_addr_i  (w_addr),
        .w_data_i  (w_data),
        .w_strb_i  (w_strb),
        .r_req_i   (r_req),
        .r_addr_i  (r_addr),
        .r_gnt_o   (r_gnt),
        .r_valid_o (r_valid),
        .r_ready_i (r_ready),
        .r_data_o  (r_data),
        .r_err_o   (r_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory as an array of words, response as one slot.
    logic [DW-1:0] mem_m [DEPTH];
    bit            m_valid = 1'b0;
    bit            m_err   = 1'b0;
    logic [DW-1:0] m_data  = '0;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % NB == 0) && (a < DEPTH * NB);
    endfunction

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 7))
            0:       return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            1:       return $urandom | 32'h0000_4000;
            default: return 32'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs at the falling edge, check the grant
    // once settled, advance the model across the rising edge and check the
    // response at the next falling edge.
    task automatic cycle(input bit rs, input bit we, input logic [31:0] wa,
                         input logic [DW-1:0] wd, input logic [NB-1:0] ws,
                         input bit rq, input logic [31:0] ra, input bit rdy);
        bit            exp_gnt;
        logic [DW-1:0] word;
        rst = rs; w_en = we; w_addr = wa; w_data = wd; w_strb = ws;
        r_req = rq; r_addr = ra; r_ready = rdy;
        #1;
        exp_gnt = !rs && rq && (!m_valid || rdy);
        chk("gnt", 32'(r_gnt), 32'(exp_gnt));

        if (exp_gnt) begin
            if (addr_ok(ra)) begin
                word = mem_m[12'(ra / NB)];
`ifdef TCM_RAM_BYPASS_EN
                if (we && addr_ok(wa) && (wa / NB == ra / NB)) begin
                    for (int k = 0; k < NB; k++) begin
                        if (ws[k]) word[k*8 +: 8] = wd[k*8 +: 8];
                    end
                end
`endif
                m_data = word;
                m_err  = 1'b0;
            end else begin
                m_data = '0;
                m_err  = 1'b1;
            end
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (rs) begin
            m_valid = 1'b0;
            m_err   = 1'b0;
        end
        if (!rs && we && addr_ok(wa)) begin
            for (int k = 0; k < NB; k++) begin
                if (ws[k]) mem_m[12'(wa / NB)][k*8 +: 8] = wd[k*8 +: 8];
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk("valid", 32'(r_valid), 32'(m_valid));
        chk("err",   32'(r_err),   32'(m_valid && m_err));
        chk("data",  r_data,       (m_valid && !m_err) ? m_data : 32'd0);
    endtask

    initial begin
        // Reset with a pending read request: nothing granted, outputs quiet
        cycle(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 1);
        cycle(1, 1, 32'h10, 32'h1234_5678, 4'hF, 1, 32'h10, 1);
        chk("rst_valid", 32'(r_valid), 32'd0);

        // First cycle out of reset: misaligned read granted at once, write 0x10
        cycle(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 32'h12, 1);
        chk("misaligned_err",  32'(r_err), 32'd1);
        chk("misaligned_data", r_data,     32'd0);

        cycle(0, 1, 32'h0, 32'h0123_4567, 4'hF, 1, 32'h10, 1);
        chk("full_write", r_data, 32'hDEAD_BEEF);

        cycle(0, 1, 32'h10, 32'h0000_00AA, 4'h1, 1, 32'h4000, 1);
        chk("oor_err", 32'(r_err), 32'd1);

        cycle(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 1);
        chk("strobe_write", r_data, 32'hDEAD_BEAA);

        cycle(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1);

        // Same-word read/write collision
        cycle(0, 1, 32'h10, 32'h1122_3344, 4'h3, 1, 32'h10, 1);
`ifdef TCM_RAM_BYPASS_EN
        chk("collision", r_data, 32'hDEAD_3344);
`else
        chk("collision", r_data, 32'hDEAD_BEEF);
`endif

        // Out-of-range write must not alias onto word 0
        cycle(0, 1, 32'h4000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 1);
        chk("oor_write_word0", r_data, 32'h0123_4567);

        // Stall three cycles; a write to the held word must not disturb it
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 1);
        cycle(0, 1, 32'h10, 32'h5555_5555, 4'hF, 1, 32'h0, 0);
        chk("stall_data", r_data, 32'hDEAD_3344);
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0);
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 0);
        chk("stall_gnt",  32'(r_gnt), 32'd0);
        chk("stall_hold", r_data,     32'hDEAD_3344);
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 1);
        chk("after_stall", r_data, 32'h0123_4567);

        // Reset in the middle of a stalled handshake drops the response
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 0);
        cycle(1, 0, 32'h0, 32'h0, 4'h0, 1, 32'h10, 0);
        chk("midrst_valid", 32'(r_valid), 32'd0);
        cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1);

        // Fill the random working set so every in-range read has known data
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 32'(i * 4), $urandom, 4'hF, 0, 32'h0, 1);
        end

        // Randomized mixed traffic, including occasional resets and stalls
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1), rnd_addr(), $urandom,
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), rnd_addr(),
                  ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tcm_ram
`default_nettype wire
